// File: rtl/mips_ucode_pkg.sv
// Shared types and constants for the microcode dispatch path.
// Opcodes, R-type functs, segment indices and fault codes.
package mips_ucode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_EOS,
        HALTED,
        FAULT
    } state_t;

    localparam logic [5:0] OPC_RTYPE  = 6'h00;
    localparam logic [5:0] OPC_J      = 6'h02;
    localparam logic [5:0] OPC_BEQ    = 6'h04;
    localparam logic [5:0] OPC_LW     = 6'h23;
    localparam logic [5:0] OPC_SW     = 6'h2B;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    localparam logic [5:0] SEG_LW     = 6'd0;
    localparam logic [5:0] SEG_SW     = 6'd1;
    localparam logic [5:0] SEG_ADD    = 6'd2;
    localparam logic [5:0] SEG_SUB    = 6'd3;
    localparam logic [5:0] SEG_AND    = 6'd4;
    localparam logic [5:0] SEG_OR     = 6'd5;
    localparam logic [5:0] SEG_SLT    = 6'd6;
    localparam logic [5:0] SEG_BEQ    = 6'd7;
    localparam logic [5:0] SEG_J      = 6'd8;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;

endpackage

// File: rtl/ucode_seg_decode.sv
// Maps a MIPS instruction word to its microcode segment index.
// Pure combinational; flags the halt opcode and unmapped encodings.
module ucode_seg_decode
    import mips_ucode_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
    input  logic [31:0] instr,
    output logic [5:0]  seg_idx,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [5:0] opc;
    logic [5:0] funct;
    logic       legal;
    logic       unused_bits;

    assign opc         = instr[31:26];
    assign funct       = instr[5:0];
    assign unused_bits = ^instr[25:6];

    // Opcode first, then funct for R-type; halt bypasses the map.
    always_comb begin
        seg_idx = '0;
        legal   = 1'b0;
        is_halt = (opc == HALT_OPCODE);
        if (!is_halt) begin
            unique case (1'b1)
                opc == OPC_LW:  begin seg_idx = SEG_LW;  legal = 1'b1; end
                opc == OPC_SW:  begin seg_idx = SEG_SW;  legal = 1'b1; end
                opc == OPC_J:   begin seg_idx = SEG_J;   legal = 1'b1; end
                opc == OPC_BEQ: begin seg_idx = SEG_BEQ; legal = 1'b1; end
                opc == OPC_RTYPE: begin
                    unique case (1'b1)
                        funct == FUNCT_ADD: begin seg_idx = SEG_ADD; legal = 1'b1; end
                        funct == FUNCT_SUB: begin seg_idx = SEG_SUB; legal = 1'b1; end
                        funct == FUNCT_AND: begin seg_idx = SEG_AND; legal = 1'b1; end
                        funct == FUNCT_OR:  begin seg_idx = SEG_OR;  legal = 1'b1; end
                        funct == FUNCT_SLT: begin seg_idx = SEG_SLT; legal = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        is_illegal = !is_halt && !legal;
    end

endmodule

// File: rtl/ucode_dispatcher.sv
// Hands one instruction at a time to the microcode unit and
// waits for its end-of-segment, with halt, illegal and watchdog paths.
module ucode_dispatcher
    import mips_ucode_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter int         CNT_W          = 32,
    parameter logic [5:0] HALT_OPCODE    = 6'h3F
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [5:0]       uc_opcode,
    output logic             uc_sos,
    input  logic             uc_eos,
    output logic [31:0]      ir_out,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    input  logic             restart,
    output logic [CNT_W-1:0] retired_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_n;
    logic [5:0]       opcode_n;
    logic             sos_n;
    logic [31:0]      ir_n;
    logic [1:0]       fc_n;
    logic [CNT_W-1:0] cnt_n;

    logic [5:0]       seg_idx;
    logic             is_halt;
    logic             is_illegal;

    ucode_seg_decode #(
        .HALT_OPCODE (HALT_OPCODE)
    ) u_decode (
        .instr      (instr),
        .seg_idx    (seg_idx),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    assign instr_ready = (state == IDLE);
    assign busy        = (state == ISSUE) || (state == WAIT_EOS);
    assign halted      = (state == HALTED);
    assign fault       = (state == FAULT);

    // Next-state and next-register values; everything holds by default.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        opcode_n = uc_opcode;
        sos_n    = 1'b0;
        ir_n     = ir_out;
        fc_n     = fault_code;
        cnt_n    = retired_count;
        unique case (state)
            IDLE: begin
                if (instr_valid) begin
                    ir_n = instr;
                    if (is_halt) begin
                        state_n  = HALTED;
                        opcode_n = HALT_OPCODE;
                    end else if (is_illegal) begin
                        state_n = FAULT;
                        fc_n    = FC_ILLEGAL;
                    end else begin
                        state_n  = ISSUE;
                        opcode_n = seg_idx;
                        sos_n    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                timer_n = '0;
                state_n = WAIT_EOS;
            end
            WAIT_EOS: begin
                if (uc_eos) begin
                    cnt_n   = retired_count + CNT_W'(1);
                    state_n = IDLE;
                end else if (timer == TIMER_LAST) begin
                    fc_n    = FC_TIMEOUT;
                    state_n = FAULT;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            HALTED: begin
                if (restart) begin
                    opcode_n = '0;
                    state_n  = IDLE;
                end
            end
            FAULT: begin
                if (restart) begin
                    opcode_n = '0;
                    fc_n     = FC_NONE;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset clears even a live segment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            uc_opcode     <= '0;
            uc_sos        <= 1'b0;
            ir_out        <= '0;
            fault_code    <= FC_NONE;
            retired_count <= '0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            uc_opcode     <= opcode_n;
            uc_sos        <= sos_n;
            ir_out        <= ir_n;
            fault_code    <= fc_n;
            retired_count <= cnt_n;
        end
    end

endmodule

// File: tb/tb_ucode_dispatcher.sv
// Scoreboard bench for ucode_dispatcher: directed scenarios plus
// randomized instruction streams against a table-driven model.
module tb_ucode_dispatcher;

    localparam int TO = 64;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic [31:0]   instr = '0;
    logic          uc_eos = 1'b0;
    logic          restart = 1'b0;
    logic          instr_ready;
    logic [5:0]    uc_opcode;
    logic          uc_sos;
    logic [31:0]   ir_out;
    logic          busy;
    logic          halted;
    logic          fault;
    logic [1:0]    fault_code;
    logic [CW-1:0] retired_count;

    ucode_dispatcher #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW),
        .HALT_OPCODE    (6'h3F)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .uc_opcode     (uc_opcode),
        .uc_sos        (uc_sos),
        .uc_eos        (uc_eos),
        .ir_out        (ir_out),
        .busy          (busy),
        .halted        (halted),
        .fault         (fault),
        .fault_code    (fault_code),
        .restart       (restart),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int seg_op[int];
    int seg_fn[int];

    typedef struct {
        logic [5:0]  seg;
        logic [31:0] word;
    } sos_exp_t;

    sos_exp_t      q_sos[$];
    logic [CW-1:0] q_cnt[$];
    logic [1:0]    q_flt[$];
    logic [31:0]   q_halt[$];
    logic [CW-1:0] model_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // 0 = legal (seg valid), 1 = illegal, 2 = halt
    function automatic int ref_decode(input logic [31:0] w, output int seg);
        int op;
        int fn;
        op  = int'(w[31:26]);
        fn  = int'(w[5:0]);
        seg = 0;
        if (op == 63) return 2;
        if (op == 0) begin
            if (seg_fn.exists(fn)) begin
                seg = seg_fn[fn];
                return 0;
            end
            return 1;
        end
        if (seg_op.exists(op)) begin
            seg = seg_op[op];
            return 0;
        end
        return 1;
    endfunction

    // Monitor: pops expectations whenever the DUT shows an event.
    logic          prev_sos = 1'b0;
    logic          prev_flt = 1'b0;
    logic          prev_hlt = 1'b0;
    logic [CW-1:0] prev_cnt = '0;
    sos_exp_t      m_e;
    logic [CW-1:0] m_c;
    logic [1:0]    m_f;
    logic [31:0]   m_h;

    always @(negedge clk) begin
        if (rst_n) begin
            if (uc_sos) begin
                chk("sos_one_cycle", 64'(prev_sos), 64'd0);
                if (q_sos.size() == 0) begin
                    chk("sos_unexpected", 64'd1, 64'd0);
                end else begin
                    m_e = q_sos.pop_front();
                    chk("sos_opcode", 64'(uc_opcode), 64'(m_e.seg));
                    chk("sos_ir_out", 64'(ir_out), 64'(m_e.word));
                end
            end
            if (retired_count !== prev_cnt) begin
                if (q_cnt.size() == 0) begin
                    chk("retire_unexpected", 64'(retired_count), 64'(prev_cnt));
                end else begin
                    m_c = q_cnt.pop_front();
                    chk("retired_count", 64'(retired_count), 64'(m_c));
                end
            end
            if (fault && !prev_flt) begin
                if (q_flt.size() == 0) begin
                    chk("fault_unexpected", 64'd1, 64'd0);
                end else begin
                    m_f = q_flt.pop_front();
                    chk("fault_code", 64'(fault_code), 64'(m_f));
                end
            end
            if (halted && !prev_hlt) begin
                if (q_halt.size() == 0) begin
                    chk("halt_unexpected", 64'd1, 64'd0);
                end else begin
                    m_h = q_halt.pop_front();
                    chk("halt_opcode", 64'(uc_opcode), 64'h3F);
                    chk("halt_ir_out", 64'(ir_out), 64'(m_h));
                end
            end
        end
        prev_sos = uc_sos;
        prev_flt = fault;
        prev_hlt = halted;
        prev_cnt = retired_count;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 200) begin
            step();
            n++;
        end
        if (!instr_ready) chk("ready_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        if (busy) chk("eos_wait_expired", 64'd1, 64'd0);
    endtask

    task automatic wait_flag(input bit want_halt);
        int n = 0;
        while (!(want_halt ? halted : fault) && n < 20) begin
            step();
            n++;
        end
        if (!(want_halt ? halted : fault)) chk("flag_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_fault_code", 64'(fault_code), 64'd0);
        chk("rst_uc_opcode", 64'(uc_opcode), 64'd0);
        chk("rst_ready", 64'(instr_ready), 64'd1);
    endtask

    // eos_delay: cycles after the sos cycle before eos rises; <0 withholds it.
    task automatic send(input logic [31:0] w, input int eos_delay);
        int seg;
        int kind;
        sos_exp_t e;
        wait_ready();
        kind = ref_decode(w, seg);
        if (kind == 0) begin
            e.seg  = 6'(seg);
            e.word = w;
            q_sos.push_back(e);
        end else if (kind == 1) begin
            q_flt.push_back(2'd1);
        end else begin
            q_halt.push_back(w);
        end
        instr       = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        if (kind == 0 && eos_delay >= 0) begin
            instr       = 32'h00221820;
            instr_valid = 1'b1;
            repeat (eos_delay) step();
            instr_valid = 1'b0;
            model_cnt++;
            q_cnt.push_back(model_cnt);
            uc_eos = 1'b1;
            wait_idle();
            uc_eos = 1'b0;
        end else if (kind == 1) begin
            wait_flag(1'b0);
            chk("fault_ready_low", 64'(instr_ready), 64'd0);
            do_restart();
        end else if (kind == 2) begin
            wait_flag(1'b1);
            chk("halt_ready_low", 64'(instr_ready), 64'd0);
            step(2);
            chk("halt_opcode_held", 64'(uc_opcode), 64'h3F);
            do_restart();
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          pick;
        int          legal_ops[4];
        int          legal_fn[5];
        legal_ops = '{'h23, 'h2B, 'h02, 'h04};
        legal_fn  = '{'h20, 'h22, 'h24, 'h25, 'h2A};
        w    = $urandom;
        pick = int'($urandom_range(0, 99));
        if (pick < 40) begin
            w[31:26] = 6'(legal_ops[$urandom_range(0, 3)]);
        end else if (pick < 82) begin
            w[31:26] = 6'h00;
            w[5:0]   = 6'(legal_fn[$urandom_range(0, 4)]);
        end else if (pick < 88) begin
            w[31:26] = 6'h00;
            w[5:0]   = 6'h3B;
        end else if (pick < 95) begin
            w[31:26] = 6'h3A;
        end else begin
            w[31:26] = 6'h3F;
        end
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

    initial begin
        sos_exp_t e;
        seg_op['h23] = 0;
        seg_op['h2B] = 1;
        seg_op['h02] = 8;
        seg_op['h04] = 7;
        seg_fn['h20] = 2;
        seg_fn['h22] = 3;
        seg_fn['h24] = 4;
        seg_fn['h25] = 5;
        seg_fn['h2A] = 6;

        step(2);
        chk("reset_sos", 64'(uc_sos), 64'd0);
        chk("reset_opcode", 64'(uc_opcode), 64'd0);
        chk("reset_ir_out", 64'(ir_out), 64'd0);
        chk("reset_fault_code", 64'(fault_code), 64'd0);
        chk("reset_count", 64'(retired_count), 64'd0);
        chk("reset_ready", 64'(instr_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        step();

        // LW, eos three cycles after sos
        send(32'h8C010004, 3);
        chk("lw_count", 64'(retired_count), 64'd1);
        chk("lw_ready", 64'(instr_ready), 64'd1);

        // SW with eos still high from before; best-case latency
        uc_eos = 1'b1;
        wait_ready();
        e.seg  = 6'd1;
        e.word = 32'hAC010004;
        q_sos.push_back(e);
        instr       = 32'hAC010004;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("stale_issue_count", 64'(retired_count), 64'(model_cnt));
        chk("stale_issue_busy", 64'(busy), 64'd1);
        model_cnt++;
        q_cnt.push_back(model_cnt);
        step();
        chk("stale_wait_count", 64'(retired_count), 64'(model_cnt - 1));
        chk("stale_wait_busy", 64'(busy), 64'd1);
        step();
        chk("latency_ready_c3", 64'(instr_ready), 64'd1);
        chk("stale_one_retire", 64'(retired_count), 64'(model_cnt));
        step(3);
        chk("stale_still_one", 64'(retired_count), 64'(model_cnt));
        uc_eos = 1'b0;

        // back-to-back SUB then SLT
        send(32'h00221822, 1);
        send(32'h0022182A, 0);
        chk("rtype_count", 64'(retired_count), 64'(model_cnt));

        // halt
        send(32'hFC000000, 0);

        // illegal opcode 3Ah
        send(32'hE8000000, 0);

        // watchdog on an ADD
        wait_ready();
        e.seg  = 6'd2;
        e.word = 32'h00221820;
        q_sos.push_back(e);
        q_flt.push_back(2'd2);
        instr       = 32'h00221820;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step(TO);
        chk("wd_no_fault_c63", 64'(fault), 64'd0);
        chk("wd_busy_c63", 64'(busy), 64'd1);
        step();
        chk("wd_fault", 64'(fault), 64'd1);
        chk("wd_code", 64'(fault_code), 64'd2);
        do_restart();

        // async reset mid-segment
        wait_ready();
        e.seg  = 6'd4;
        e.word = 32'h00221824;
        q_sos.push_back(e);
        instr       = 32'h00221824;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_sos", 64'(uc_sos), 64'd0);
        chk("ar_opcode", 64'(uc_opcode), 64'd0);
        chk("ar_ir_out", 64'(ir_out), 64'd0);
        chk("ar_count", 64'(retired_count), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_ready", 64'(instr_ready), 64'd1);
        model_cnt = '0;
        step();
        rst_n = 1'b1;
        step();
        send(32'h8C010004, 1);
        chk("ar_after_count", 64'(retired_count), 64'd1);

        // randomized stream
        for (int i = 0; i < 150; i++) begin
            send(rand_instr(), int'($urandom_range(0, 6)));
        end
        chk("rand_count", 64'(retired_count), 64'(model_cnt));

        step(3);
        chk("q_sos_empty", 64'(q_sos.size()), 64'd0);
        chk("q_cnt_empty", 64'(q_cnt.size()), 64'd0);
        chk("q_flt_empty", 64'(q_flt.size()), 64'd0);
        chk("q_halt_empty", 64'(q_halt.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
